// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-time sequencer for a programmable divide-by-N counter.
// Produces a one-cycle tick at the end of every period and a registered
// divided clock. New ratios arrive via valid/ready and take effect only at
// period boundaries, so the divided clock never glitches.
module clk_div_ctrl #(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = 4,
  parameter int BURST_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_div,
  input  logic               cfg_burst,
  input  logic [BURST_W-1:0] cfg_count,
  output logic               tick,
  output logic               clk_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic               burst_q, burst_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]   pend_div_q, pend_div_d;
  logic               pend_burst_q, pend_burst_d;
  logic [BURST_W-1:0] pend_count_q, pend_count_d;
  logic               clk_out_q, clk_out_d;
  logic               done_q, done_d;

  logic               running;
  logic               boundary;
  logic               cfg_xfer;
  logic [WIDTH-1:0]   cfg_div_cl;
  logic [BURST_W-1:0] cfg_count_cl;

  // Ratios below 2 cannot form a period with both a high and low phase;
  // a zero burst length would never terminate, so it means one tick.
  assign cfg_div_cl   = (cfg_div < WIDTH'(2)) ? WIDTH'(2) : cfg_div;
  assign cfg_count_cl = (cfg_count == '0) ? BURST_W'(1) : cfg_count;

  assign running   = (state_q != IDLE);
  assign cfg_ready = running ? !pend_valid_q : 1'b1;
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign boundary  = running && (cnt_q == div_q - WIDTH'(1));

  assign tick    = boundary;
  assign busy    = running;
  assign clk_out = clk_out_q;
  assign done    = done_q;

  // Next-state: config capture, period counting, burst/stop termination.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    burst_d      = burst_q;
    count_d      = count_q;
    rem_d        = rem_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    pend_burst_d = pend_burst_q;
    pend_count_d = pend_count_q;
    done_d       = 1'b0;

    if (state_q == IDLE) begin
      // A slot left over from the previous run is applied on start; a config
      // offered on the same edge is newer and wins.
      if (start && pend_valid_q) begin
        div_d        = pend_div_q;
        burst_d      = pend_burst_q;
        count_d      = pend_count_q;
        pend_valid_d = 1'b0;
      end
      if (cfg_xfer) begin
        div_d   = cfg_div_cl;
        burst_d = cfg_burst;
        count_d = cfg_count_cl;
      end
      if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        rem_d   = count_d;
      end
    end else begin
      // cfg_ready is low whenever the slot is full, so this never collides
      // with the slot being drained at a boundary below.
      if (cfg_xfer) begin
        pend_valid_d = 1'b1;
        pend_div_d   = cfg_div_cl;
        pend_burst_d = cfg_burst;
        pend_count_d = cfg_count_cl;
      end
      if (boundary) begin
        cnt_d = '0;
        if ((state_q == STOPPING) || stop || (burst_q && rem_q == BURST_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (burst_q) begin
          rem_d = rem_q - BURST_W'(1);
        end
        if (pend_valid_q) begin
          div_d        = pend_div_q;
          burst_d      = pend_burst_q;
          count_d      = pend_count_q;
          rem_d        = pend_count_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (state_q == RUN && stop) state_d = STOPPING;
      end
    end

    // Divided clock follows the next count against the next ratio, so a new
    // ratio shapes its very first period correctly.
    clk_out_d = (state_d != IDLE) && (cnt_d < (div_d >> 1));
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= WIDTH'(DIV_RESET);
      burst_q      <= 1'b0;
      count_q      <= BURST_W'(1);
      rem_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      pend_burst_q <= 1'b0;
      pend_count_q <= '0;
      clk_out_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      burst_q      <= burst_d;
      count_q      <= count_d;
      rem_q        <= rem_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      pend_burst_q <= pend_burst_d;
      pend_count_q <= pend_count_d;
      clk_out_q    <= clk_out_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: period-level reference model compared every cycle,
// plus hand-computed tick/done/clk_out timelines for the directed scenarios.
module tb_clk_div_ctrl;

  logic        clk, rst, start, stop, cfg_valid, cfg_burst;
  logic        cfg_ready, tick, clk_out, busy, done;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_count;

  clk_div_ctrl #(.WIDTH(16), .DIV_RESET(4), .BURST_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div),
    .cfg_burst(cfg_burst), .cfg_count(cfg_count),
    .tick(tick), .clk_out(clk_out), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (period position based) ----------------
  typedef struct { int n; bit b; int c; } cfg_t;
  bit   m_run, m_stopping, m_done;
  int   m_pos, m_n, m_left, m_cnt;
  bit   m_burst;
  cfg_t pend[$];

  function automatic cfg_t mk_cfg();
    cfg_t r;
    r.n = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
    r.b = cfg_burst;
    r.c = (cfg_count == 0) ? 1 : int'(cfg_count);
    return r;
  endfunction

  task automatic m_apply(input cfg_t c);
    m_n = c.n; m_burst = c.b; m_cnt = c.c;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 0; m_stopping = 0; m_done = 0; m_pos = 0;
      m_n = 4; m_burst = 0; m_cnt = 1; m_left = 0;
      pend.delete();
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && pend.size() > 0) m_apply(pend.pop_front());
        if (cfg_valid) m_apply(mk_cfg());
        if (start) begin
          m_run = 1; m_stopping = 0; m_pos = 0; m_left = m_cnt;
        end
      end else begin
        bit   accept, fin;
        cfg_t nc;
        accept = cfg_valid && (pend.size() == 0);
        nc = mk_cfg();
        if (m_pos == m_n - 1) begin
          fin = m_stopping || stop || (m_burst && m_left == 1);
          if (!fin && m_burst) m_left--;
          if (pend.size() > 0) begin
            m_apply(pend.pop_front());
            m_left = m_cnt;
          end
          if (fin) begin m_run = 0; m_done = 1; end
          m_pos = 0;
        end else begin
          m_pos++;
          if (stop) m_stopping = 1;
        end
        if (accept) pend.push_back(nc);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("tick",      tick,      int'(m_run && (m_pos == m_n - 1)));
      cmp("clk_out",   clk_out,   int'(m_run && (m_pos < m_n / 2)));
      cmp("busy",      busy,      int'(m_run));
      cmp("done",      done,      int'(m_done));
      cmp("cfg_ready", cfg_ready, int'(!m_run || pend.size() == 0));
    end
  end

  // ---------------- timeline logging relative to the start edge ------------
  int cyc = 0, mark = 0;
  bit log_en = 0;
  int tick_log[$];
  int done_log[$];
  logic [15:0] clk_bits;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (log_en) begin
      int rel;
      rel = cyc - mark + 1;
      if (tick) tick_log.push_back(rel);
      if (done) done_log.push_back(rel);
      if (rel >= 1 && rel <= 16) clk_bits[16 - rel] = clk_out;
    end
  end

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    mark = cyc;
    tick_log.delete();
    done_log.delete();
    clk_bits = '0;
    log_en = 1;
  endtask

  // Holds cfg_valid until the handshake completes; returns stalled cycles.
  task automatic send_cfg(input int div, input bit b, input int cnt, output int stalls);
    bit acc;
    stalls = 0;
    cfg_valid = 1'b1; cfg_div = 16'(div); cfg_burst = b; cfg_count = 8'(cnt);
    for (int i = 0; i < 100; i++) begin
      acc = cfg_ready;
      step();
      if (acc) break;
      stalls++;
    end
    cfg_valid = 1'b0;
    if (stalls >= 100) cmp("cfg_handshake_timeout", 1, 0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 100) begin step(); k++; end
    if (busy) cmp(name, 1, 0);
  endtask

  task automatic stop_run(input string name);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle(name);
  endtask

  int st;

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_div = '0; cfg_burst = 1'b0; cfg_count = '0;
    #1 rst = 1'b1;
    #3;
    cmp("rst_tick", tick, 0);
    cmp("rst_clk_out", clk_out, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_cfg_ready", cfg_ready, 1);
    chk_en = 1;
    step();
    rst = 1'b0;
    step();

    // Default ratio 4 after reset.
    do_start();
    steps(12);
    cmp("n4_tick0", q_at(tick_log, 0), 4);
    cmp("n4_tick1", q_at(tick_log, 1), 8);
    cmp("n4_tick2", q_at(tick_log, 2), 12);
    cmp("n4_clk_pattern", int'(clk_bits[15:8]), 8'b1100_1100);
    cmp("n4_busy", busy, 1);
    stop_run("n4_stop_timeout");

    // Ratio 5 programmed in IDLE: high 2, low 3.
    send_cfg(5, 0, 0, st);
    do_start();
    steps(15);
    cmp("n5_tick0", q_at(tick_log, 0), 5);
    cmp("n5_tick1", q_at(tick_log, 1), 10);
    cmp("n5_tick2", q_at(tick_log, 2), 15);
    cmp("n5_clk_pattern", int'(clk_bits[15:11]), 5'b11000);
    stop_run("n5_stop_timeout");

    // Mid-run reprogramming at N=4: 10 queued, then 6 stalls behind it.
    send_cfg(4, 0, 0, st);
    do_start();
    step();                      // now in cycle 2
    send_cfg(10, 0, 0, st);      // accepted at end of cycle 2
    cmp("pend_ready_low", cfg_ready, 0);
    send_cfg(6, 0, 0, st);
    cmp("pend_stall_cycles", st, 2);
    steps(22);
    cmp("reprog_tick0", q_at(tick_log, 0), 4);
    cmp("reprog_tick1", q_at(tick_log, 1), 14);
    cmp("reprog_tick2", q_at(tick_log, 2), 20);
    cmp("reprog_tick3", q_at(tick_log, 3), 26);
    stop_run("reprog_stop_timeout");

    // Burst of 3 at N=6.
    send_cfg(6, 1, 3, st);
    do_start();
    steps(25);
    cmp("burst_nticks", tick_log.size(), 3);
    cmp("burst_tick0", q_at(tick_log, 0), 6);
    cmp("burst_tick1", q_at(tick_log, 1), 12);
    cmp("burst_tick2", q_at(tick_log, 2), 18);
    cmp("burst_ndone", done_log.size(), 1);
    cmp("burst_done_cycle", q_at(done_log, 0), 19);
    cmp("burst_busy_after", busy, 0);

    // Stop at cnt=1, N=8.
    send_cfg(8, 0, 0, st);
    do_start();
    step();                      // cycle 2, cnt = 1
    stop = 1'b1;
    step();
    stop = 1'b0;
    steps(10);
    cmp("stop_nticks", tick_log.size(), 1);
    cmp("stop_tick0", q_at(tick_log, 0), 8);
    cmp("stop_done_cycle", q_at(done_log, 0), 9);
    cmp("stop_clk_out", clk_out, 0);
    cmp("stop_busy", busy, 0);

    // Ratio 0 clamps to 2.
    send_cfg(0, 0, 0, st);
    do_start();
    steps(6);
    cmp("div0_tick0", q_at(tick_log, 0), 2);
    cmp("div0_tick1", q_at(tick_log, 1), 4);
    cmp("div0_tick2", q_at(tick_log, 2), 6);
    cmp("div0_clk_pattern", int'(clk_bits[15:12]), 4'b1010);
    stop_run("div0_stop_timeout");

    // Ratio 1 clamps to 2, then reset mid-run drops a queued config.
    send_cfg(1, 0, 0, st);
    do_start();
    steps(4);
    cmp("div1_tick0", q_at(tick_log, 0), 2);
    cmp("div1_tick1", q_at(tick_log, 1), 4);
    send_cfg(10, 0, 0, st);
    rst = 1'b1;
    #1;
    cmp("midrst_tick", tick, 0);
    cmp("midrst_clk_out", clk_out, 0);
    cmp("midrst_busy", busy, 0);
    cmp("midrst_done", done, 0);
    cmp("midrst_cfg_ready", cfg_ready, 1);
    step();
    rst = 1'b0;
    step();
    do_start();
    steps(9);
    cmp("postrst_tick0", q_at(tick_log, 0), 4);
    cmp("postrst_tick1", q_at(tick_log, 1), 8);
    stop_run("postrst_stop_timeout");

    steps(2);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the system clock divider. It sequences a programmable divide-by-N counter that supplies the sampling tick and divided clock to the sequence detector datapath. The controller accepts new divide ratios through a valid/ready handshake and applies them glitch-free at period boundaries. It supports continuous and fixed-length burst operation, with start and stop control.

## Interface
- WIDTH, 16: width of divide ratio and period counter
- DIV_RESET, 4: divide ratio active after reset (must be ≥ 2)
- BURST_W, 8: width of burst tick count

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin generation; honoured only in IDLE
- stop  in  1  request stop; honoured in RUN; ignored elsewhere
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept configuration
- cfg_div  in  WIDTH  requested divide ratio N
- cfg_burst  in  1  0 = continuous, 1 = burst
- cfg_count  in  BURST_W  ticks per burst (0 treated as 1)
- tick  out  1  one-cycle pulse at last cycle of each period
- clk_out  out  1  divided clock, registered
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, RUN, STOPPING.
- Active config registers: div_q, burst_q, count_q. One pending slot: pend_valid, pend_div, pend_burst, pend_count.
- Ratio clamp: any cfg_div < 2 is stored as 2. No other arithmetic is applied. The counter is WIDTH bits and runs 0..div_q−1, then wraps to 0.
- Handshake: a transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = 1 in IDLE.
  - cfg_ready = !pend_valid in RUN and STOPPING.
  - In IDLE, an accepted config is written straight into the active registers.
  - Otherwise it is written into the pending slot.
- Boundary: the cycle with cnt == div_q−1 while in RUN or STOPPING.
  - tick = 1 in that cycle only.
  - On the following edge, cnt ← 0. If pend_valid, pending values are copied to active and pend_valid ← 0. A burst in progress restarts its remaining count from the new count_q.
- IDLE→RUN: start = 1 at an edge. cnt ← 0, remaining ← count_q. If cfg_valid is also high on that edge, the new config is accepted first and takes effect for this run.
- RUN, continuous mode: loops indefinitely.
- RUN, burst mode: remaining decrements at each boundary. At the boundary where remaining == 1, the next state is IDLE and done pulses.
- stop in RUN: next state is STOPPING. The current period completes. At its boundary, the next state is IDLE and done pulses. stop is ignored in IDLE and STOPPING.
- Entering IDLE: cnt ← 0, clk_out ← 0. The pending slot is retained and applied on the next start.
- clk_out: registered. Its next value is 1 when the next cnt < (div_q >> 1) and state is RUN/STOPPING, otherwise 0.
  - Even N gives 50 % duty cycle.
  - Odd N is low for one extra cycle.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, div_q = DIV_RESET, burst_q = 0, count_q = 1
  - pend_valid = 0
  - tick = 0, clk_out = 0, busy = 0, done = 0, cfg_ready = 1
- Reset mid-run returns immediately to these values. The pending config is lost.
- First tick: for start sampled at edge E, tick is high in the cycle after edge E+N−1, i.e. N cycles after start. Subsequent ticks follow every N cycles.
- clk_out first rises on edge E.
- done is high for exactly the one cycle after the final boundary. busy falls in the same cycle.
- Config applied at a boundary governs the very next period; there is no dead cycle.
- Simultaneous events:
  - stop on a burst-final boundary: done fires once.
  - cfg accept on a boundary cycle while pending is empty: the write lands in pending, and is applied at the next boundary, not the current one.

## Test plan
- Reset, then start with DIV_RESET = 4 → tick at cycles 4, 8, 12; clk_out pattern 1100 repeating; busy = 1.
- In IDLE, write cfg_div = 5, continuous, then start → tick every 5 cycles; clk_out high 2 / low 3.
- In RUN at N = 4, write cfg_div = 10 mid-period → cfg_ready drops until the boundary; the old period ends on schedule; the next tick arrives 10 cycles later; a second write is stalled while pending.
- Burst with cfg_count = 3, N = 6 → exactly 3 ticks at cycles 6, 12, 18; done pulses in cycle 19; busy = 0 afterwards.
- stop asserted at cnt = 1 with N = 8 → one more tick at cnt = 7, then IDLE with done; clk_out = 0.
- cfg_div = 0 and 1 → behaves as N = 2, ticking every 2 cycles; rst asserted mid-run → all outputs reset to their reset values immediately.
